// File: rtl/frame_assembler.sv
// Ping-pong frame assembler: gathers NUM_CH-word ADC bursts into two
// frame slots and streams complete frames downstream with valid/ready.
module frame_assembler #(
  parameter int NUM_CH         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        sresetn,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic [15:0] out_data,
  output logic [2:0]  out_chan,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic [7:0]  drop_count
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } rstate_e;

  wstate_e ws_q, ws_d;
  rstate_e rs_q, rs_d;

  logic          wr_slot_q, wr_slot_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    full_q, full_d;
  logic          rd_slot_q, rd_slot_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;

  logic [15:0]   mem_q [2][NUM_CH];

  logic wr_en;
  logic wr_done;
  logic ev_ovf;
  logic ev_tmo;
  logic tmo_hit;
  logic rd_fire;
  logic rd_done;
  logic rd_avail;

  // Idle-gap watchdog fires on the last allowed quiet cycle of a burst
  always_comb begin
    tmo_hit = (ws_q != W_IDLE) && !in_valid && (tmo_q == TMO_LAST);
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) ws_q <= W_IDLE;
    else          ws_q <= ws_d;
  end

  // Write FSM next-state decision
  always_comb begin
    ws_d = ws_q;
    unique case (ws_q)
      W_IDLE: begin
        if (in_valid && (LAST != '0)) begin
          if (full_q[wr_slot_q]) ws_d = W_DROP;
          else                   ws_d = W_FILL;
        end
      end
      W_FILL, W_DROP: begin
        if (tmo_hit)                            ws_d = W_IDLE;
        else if (in_valid && wr_idx_q == LAST)  ws_d = W_IDLE;
      end
      default: ws_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: slot index, gap counter and drop events
  always_comb begin
    wr_slot_d = wr_slot_q;
    wr_idx_d  = wr_idx_q;
    tmo_d     = tmo_q;
    wr_en     = 1'b0;
    wr_done   = 1'b0;
    ev_ovf    = 1'b0;
    ev_tmo    = 1'b0;
    unique case (ws_q)
      W_IDLE: begin
        tmo_d = '0;
        if (in_valid) begin
          wr_idx_d = (LAST == '0) ? '0 : IW'(1);
          if (full_q[wr_slot_q]) begin
            ev_ovf = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_done = (LAST == '0);
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          tmo_d = '0;
          wr_en = 1'b1;
          if (wr_idx_q == LAST) begin
            wr_done  = 1'b1;
            wr_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end else if (tmo_hit) begin
          tmo_d    = '0;
          wr_idx_d = '0;
          ev_tmo   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      W_DROP: begin
        if (in_valid) begin
          tmo_d = '0;
          if (wr_idx_q == LAST) wr_idx_d = '0;
          else                  wr_idx_d = wr_idx_q + IW'(1);
        end else if (tmo_hit) begin
          tmo_d    = '0;
          wr_idx_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        tmo_d    = '0;
        wr_idx_d = '0;
      end
    endcase
    if (wr_done) wr_slot_d = ~wr_slot_q;
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) rs_q <= R_IDLE;
    else          rs_q <= rs_d;
  end

  // A frame completing into the read slot this cycle is sent next cycle
  always_comb begin
    rd_fire  = (rs_q == R_SEND) && out_ready;
    rd_done  = rd_fire && (rd_idx_q == LAST);
    rd_avail = full_q[rd_slot_q] || (wr_done && (wr_slot_q == rd_slot_q));
  end

  // Read FSM next-state decision
  always_comb begin
    rs_d = rs_q;
    unique case (rs_q)
      R_IDLE:  if (rd_avail) rs_d = R_SEND;
      R_SEND:  if (rd_done)  rs_d = R_IDLE;
      default: rs_d = R_IDLE;
    endcase
  end

  // Read FSM outputs: word index and slot pointer advance on handshake
  always_comb begin
    rd_idx_d  = rd_idx_q;
    rd_slot_d = rd_slot_q;
    if (rd_fire) begin
      if (rd_done) begin
        rd_idx_d  = '0;
        rd_slot_d = ~rd_slot_q;
      end else begin
        rd_idx_d = rd_idx_q + IW'(1);
      end
    end
  end

  // Slot full flags: set by writer, cleared by reader, never same slot
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wr_slot_q] = 1'b1;
    if (rd_done) full_d[rd_slot_q] = 1'b0;
  end

  // Sticky overflow and saturating drop counter
  always_comb begin
    ovf_d  = (ovf_q && !clr_ovf) || ev_ovf;
    drop_d = drop_q;
    if ((ev_ovf || ev_tmo) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      wr_slot_q <= 1'b0;
      wr_idx_q  <= '0;
      tmo_q     <= '0;
      full_q    <= 2'b00;
      rd_slot_q <= 1'b0;
      rd_idx_q  <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      wr_slot_q <= wr_slot_d;
      wr_idx_q  <= wr_idx_d;
      tmo_q     <= tmo_d;
      full_q    <= full_d;
      rd_slot_q <= rd_slot_d;
      rd_idx_q  <= rd_idx_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  // Frame storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_slot_q][wr_idx_q] <= in_data;
  end

  // Outputs are forced to zero whenever no word is presented
  always_comb begin
    out_valid  = (rs_q == R_SEND);
    out_data   = out_valid ? mem_q[rd_slot_q][rd_idx_q] : 16'h0000;
    out_chan   = out_valid ? 3'(rd_idx_q) : 3'd0;
    out_last   = out_valid && (rd_idx_q == LAST);
    overflow   = ovf_q;
    drop_count = drop_q;
  end

endmodule

// File: tb/tb_frame_assembler.sv
// Scoreboard bench for frame_assembler: random and directed bursts,
// expected frames queued by a slot-occupancy model, checked by a monitor.
module tb_frame_assembler;

  localparam int NUM_CH = 8;
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        sresetn = 1'b1;
  logic [15:0] in_data = 16'h0;
  logic        in_valid = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_chan;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        overflow;
  logic        clr_ovf = 1'b0;
  logic [7:0]  drop_count;

  frame_assembler #(
    .NUM_CH(NUM_CH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .sresetn(sresetn),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_data(out_data),
    .out_chan(out_chan),
    .out_valid(out_valid),
    .out_last(out_last),
    .out_ready(out_ready),
    .overflow(overflow),
    .clr_ovf(clr_ovf),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected words: {last, chan, data}
  logic [19:0] exp_q[$];
  int held = 0;
  int exp_drops = 0;
  int exp_ovf = 0;
  int rmode = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic void note_drop(input bit ovf);
    if (exp_drops < 255) exp_drops++;
    if (ovf) exp_ovf = 1;
  endfunction

  task automatic drive_cycle(input logic v, input logic [15:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
  endtask

  // A burst is kept iff fewer than two complete frames are still
  // waiting when its first word arrives.
  task automatic send_burst(input logic [15:0] base, input int nw,
                            input int gap, input int long_gap);
    bit acc;
    logic [19:0] fr[$];
    acc = 1'b0;
    for (int i = 0; i < nw; i++) begin
      if (i > 0 && gap > 0)
        repeat ($urandom_range(gap, 0)) drive_cycle(1'b0, 16'h0);
      if (i == NUM_CH / 2 && long_gap > 0)
        repeat (long_gap) drive_cycle(1'b0, 16'h0);
      drive_cycle(1'b1, base + 16'(i));
      if (i == 0) begin
        acc = (held < 2);
        if (!acc) note_drop(1'b1);
      end
      fr.push_back({(i == NUM_CH - 1), 3'(i), base + 16'(i)});
    end
    if (nw == NUM_CH) begin
      if (acc) begin
        foreach (fr[k]) exp_q.push_back(fr[k]);
        held++;
      end
    end else begin
      repeat (TMO + 2) drive_cycle(1'b0, 16'h0);
      if (acc) note_drop(1'b0);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      drive_cycle(1'b0, 16'h0);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words still pending, required 0",
               exp_q.size());
    end
    repeat (4) drive_cycle(1'b0, 16'h0);
    chk("idle_after_drain", int'(out_valid), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    sresetn  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    exp_q.delete();
    held      = 0;
    exp_drops = 0;
    exp_ovf   = 0;
    repeat (3) @(posedge clk);
    #3;
    sresetn = 1'b1;
  endtask

  // downstream ready pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(99, 0) < 55);
      endcase
    end
  end

  // monitor: pops expected words on handshakes, checks stall stability
  initial begin
    logic [19:0] got;
    logic [19:0] stall_word;
    logic [19:0] e;
    bit stall;
    stall = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      got = {out_last, out_chan, out_data};
      if (!sresetn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (!out_valid || got != stall_word) begin
            errors++;
            $display("FAIL stall_stable: got v=%0b %h, held %h",
                     out_valid, got, stall_word);
          end
        end
        if (out_valid && out_ready) begin
          stall = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h, expected none", got);
          end else begin
            e = exp_q.pop_front();
            if (got != e) begin
              errors++;
              $display("FAIL word: got %h, expected %h", got, e);
            end
            if (e[19]) held--;
          end
        end else if (out_valid) begin
          stall = 1'b1;
          stall_word = got;
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();

    // single burst, latency and channel order
    rmode = 1;
    drive_cycle(1'b0, 16'h0);
    drive_cycle(1'b0, 16'h0);
    send_burst(16'h1000, NUM_CH, 0, 0);
    chk("lat_before", int'(out_valid), 0);
    drive_cycle(1'b0, 16'h0);
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_chan0", int'(out_chan), 0);
    chk("lat_data0", int'(out_data), 16'h1000);
    wait_drain();

    // partial burst times out, then a normal burst
    send_burst(16'h2000, 5, 0, 0);
    chk("tmo_drops", int'(drop_count), exp_drops);
    chk("tmo_no_out", int'(out_valid), 0);
    send_burst(16'h2100, NUM_CH, 1, 0);
    // a gap one short of the timeout keeps the burst alive
    send_burst(16'h2200, NUM_CH, 0, TMO - 1);
    wait_drain();
    chk("tmo_drops_after", int'(drop_count), exp_drops);

    // three bursts against a stalled sink
    do_reset();
    rmode = 0;
    send_burst(16'h3000, NUM_CH, 0, 0);
    send_burst(16'h3100, NUM_CH, 0, 0);
    send_burst(16'h3200, NUM_CH, 0, 0);
    drive_cycle(1'b0, 16'h0);
    chk("ovf3_overflow", int'(overflow), exp_ovf);
    chk("ovf3_drops", int'(drop_count), exp_drops);
    repeat (10) drive_cycle(1'b0, 16'h0);
    chk("ovf3_held", int'(out_valid), 1);
    rmode = 1;
    wait_drain();

    // random bursts with random backpressure
    do_reset();
    rmode = 2;
    for (int b = 0; b < 100; b++) begin
      send_burst(16'($urandom_range(65535, 0)), NUM_CH, 3, 0);
      repeat ($urandom_range(4, 0)) drive_cycle(1'b0, 16'h0);
    end
    rmode = 1;
    wait_drain();
    chk("rand_drops", int'(drop_count), exp_drops);
    chk("rand_overflow", int'(overflow), exp_ovf);

    // reset mid-burst while a frame is half sent
    rmode = 0;
    send_burst(16'h4000, NUM_CH, 0, 0);
    rmode = 1;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 16'h4100 + 16'(i));
    do_reset();
    repeat (12) drive_cycle(1'b0, 16'h0);
    chk("post_rst_valid", int'(out_valid), 0);
    send_burst(16'h4200, NUM_CH, 2, 0);
    wait_drain();

    // drop counter saturation and overflow clear
    do_reset();
    rmode = 0;
    for (int b = 0; b < 302; b++)
      send_burst(16'h5000 + 16'(b * 16), NUM_CH, 0, 0);
    drive_cycle(1'b0, 16'h0);
    chk("sat_drops", int'(drop_count), exp_drops);
    chk("sat_overflow", int'(overflow), exp_ovf);
    clr_ovf = 1'b1;
    drive_cycle(1'b0, 16'h0);
    clr_ovf = 1'b0;
    exp_ovf = 0;
    drive_cycle(1'b0, 16'h0);
    chk("clr_overflow", int'(overflow), exp_ovf);
    chk("clr_keeps_drops", int'(drop_count), 255);
    rmode = 1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
